// File: rtl/switch_debounce.sv
// ---------------------------------------------------------------------------
// switch_debounce
//
// Synchronised, debounced input stage for the MegaWing slide switches.
// Each of WIDTH asynchronous switch lines is brought into the CLK domain by
// a two-flop synchroniser. A per-bit two-state machine (STABLE / CHECK) then
// accepts a new level only after the synchronised input has differed from
// the debounced output for DEBOUNCE_CYCLES consecutive clocks. A one-cycle
// change pulse and mask let downstream capture registers load only on real
// transitions.
//
// Optional feature macro: SWITCH_DEBOUNCE_EDGE_EN
//   When defined, the RISE and FALL edge-qualified masks are added.
//
// Parameters
//   WIDTH            number of switch lines (1..16)
//   DEBOUNCE_CYCLES  consecutive differing samples to accept a level (2..65535)
//
// Ports
//   CLK           in   1      rising-edge clock
//   RESETN        in   1      asynchronous active-low reset
//   I             in   WIDTH  raw switch levels (asynchronous)
//   O             out  WIDTH  debounced levels, registered
//   CHANGED       out  1      one-cycle pulse in the cycle O first shows a new value
//   CHANGED_MASK  out  WIDTH  bits of O that changed while CHANGED is high
//   RISE          out  WIDTH  CHANGED_MASK & O   (SWITCH_DEBOUNCE_EDGE_EN only)
//   FALL          out  WIDTH  CHANGED_MASK & ~O  (SWITCH_DEBOUNCE_EDGE_EN only)
// ---------------------------------------------------------------------------
module switch_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] O,
  output logic             CHANGED,
  output logic [WIDTH-1:0] CHANGED_MASK
`ifdef SWITCH_DEBOUNCE_EDGE_EN
  ,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL
`endif
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  // Last count value before acceptance; the counter never goes beyond it.
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } state_e;

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;
  state_e           state_q [WIDTH];
  state_e           state_d [WIDTH];
  logic [CNT_W-1:0] cnt_q   [WIDTH];
  logic [CNT_W-1:0] cnt_d   [WIDTH];
  logic [WIDTH-1:0] o_q;
  logic [WIDTH-1:0] o_d;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;
  logic             changed_q;

  // Two-flop synchroniser; only s2_q is used downstream.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      s1_q <= {WIDTH{1'b0}};
      s2_q <= {WIDTH{1'b0}};
    end else begin
      s1_q <= I;
      s2_q <= s1_q;
    end
  end

  // Per-bit debounce next-state logic; all bits are evaluated independently.
  always_comb begin
    o_d    = o_q;
    mask_d = {WIDTH{1'b0}};
    for (int b = 0; b < WIDTH; b++) begin
      state_d[b] = state_q[b];
      cnt_d[b]   = cnt_q[b];
      case (state_q[b])
        ST_STABLE: begin
          if (s2_q[b] != o_q[b]) begin
            cnt_d[b]   = CNT_ONE;
            state_d[b] = ST_CHECK;
          end else begin
            cnt_d[b]   = CNT_ZERO;
            state_d[b] = ST_STABLE;
          end
        end
        ST_CHECK: begin
          if (s2_q[b] == o_q[b]) begin
            // Input bounced back: discard the partial count.
            cnt_d[b]   = CNT_ZERO;
            state_d[b] = ST_STABLE;
          end else if (cnt_q[b] == CNT_MAX) begin
            o_d[b]     = s2_q[b];
            mask_d[b]  = 1'b1;
            cnt_d[b]   = CNT_ZERO;
            state_d[b] = ST_STABLE;
          end else begin
            cnt_d[b]   = cnt_q[b] + CNT_ONE;
          end
        end
        default: begin
          cnt_d[b]   = CNT_ZERO;
          state_d[b] = ST_STABLE;
        end
      endcase
    end
  end

  // Per-bit state and counter registers.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      for (int b = 0; b < WIDTH; b++) begin
        state_q[b] <= ST_STABLE;
        cnt_q[b]   <= CNT_ZERO;
      end
    end else begin
      for (int b = 0; b < WIDTH; b++) begin
        state_q[b] <= state_d[b];
        cnt_q[b]   <= cnt_d[b];
      end
    end
  end

  // Output registers; CHANGED is derived from the same next-state mask so it
  // lines up with the cycle in which O first shows the new value.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      o_q       <= {WIDTH{1'b0}};
      mask_q    <= {WIDTH{1'b0}};
      changed_q <= 1'b0;
    end else begin
      o_q       <= o_d;
      mask_q    <= mask_d;
      changed_q <= |mask_d;
    end
  end

  assign O            = o_q;
  assign CHANGED      = changed_q;
  assign CHANGED_MASK = mask_q;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;

  // Edge-qualified masks, aligned with CHANGED_MASK.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      rise_q <= {WIDTH{1'b0}};
      fall_q <= {WIDTH{1'b0}};
    end else begin
      rise_q <= mask_d & o_d;
      fall_q <= mask_d & ~o_d;
    end
  end

  assign RISE = rise_q;
  assign FALL = fall_q;
`endif

endmodule
